// File: rtl/wordcopy_dma_if.sv
// ============================================================================
// Module   : wordcopy_dma_if
// Brief    : Avalon-MM style bus bundle, used for both the CSR slave and the
//            SDRAM master port of the word copy/fill engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wordcopy_dma_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          waitrequest;
    logic [AW-1:0] address;
    logic          read;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          write;
    logic [DW-1:0] writedata;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, read, write, writedata
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, read, write, writedata
    );
endinterface

`default_nettype wire

// File: rtl/wordcopy_dma.sv
// ============================================================================
// Module   : wordcopy_dma
// Brief    : Non-blocking word copy/fill engine with pipelined SDRAM reads
//            and a read-data FIFO that also bounds the reads in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wordcopy_dma #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    wordcopy_dma_if.slave  csr,
    wordcopy_dma_if.master mem,
    output logic           irq
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0]     C_BYTES = 32'(DW / 8);
    localparam logic [PW+1:0]   C_DEPTH = (PW + 2)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} state_t;

    state_t          r_state, w_state_nx;
    logic [31:0]     r_dest, r_src, r_numwords, r_pattern;
    logic            r_mode, r_fill, r_irq_en, r_done, r_aborted;
    logic [31:0]     r_rd_cnt, r_wr_cnt;
    logic [PW:0]     r_inflight, r_count;
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [DW-1:0]   r_fifo [FIFO_DEPTH];
    logic            r_m_read, r_m_write;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;

    logic            w_busy, w_ctrl_wr, w_start, w_abort, w_flush;
    logic            w_rd_acc, w_wr_acc, w_hold, w_rdv, w_push, w_pop, w_fill_nx;
    logic            w_can_wr, w_can_rd;
    logic [31:0]     w_rd_cnt_nx, w_wr_cnt_nx, w_rdata;
    logic [PW:0]     w_inflight_nx, w_count_nx;
    logic [PW-1:0]   w_rptr_nx;
    logic [DW-1:0]   w_head;
    logic            w_unused;

    assign w_busy    = (r_state == S_RUN) || (r_state == S_ABORT);
    assign w_ctrl_wr = csr.write && (csr.address == 4'd0);
    assign w_start   = w_ctrl_wr && csr.writedata[0] && (r_state == S_IDLE);
    assign w_abort   = w_ctrl_wr && csr.writedata[1] && (r_state == S_RUN);
    assign w_unused  = &{1'b0, csr.read};

    always_comb begin
        w_rd_acc      = r_m_read && !mem.waitrequest;
        w_wr_acc      = r_m_write && !mem.waitrequest;
        w_hold        = (r_m_read || r_m_write) && mem.waitrequest;
        // Responses with nothing outstanding (e.g. after a reset) are dropped.
        w_rdv         = mem.readdatavalid && (r_inflight != '0);
        w_push        = w_rdv && (r_state == S_RUN);
        w_pop         = w_wr_acc && !r_fill && (r_state == S_RUN);
        w_rd_cnt_nx   = w_start ? 32'd0 : r_rd_cnt + 32'(w_rd_acc);
        w_wr_cnt_nx   = w_start ? 32'd0 : r_wr_cnt + 32'(w_wr_acc);
        w_inflight_nx = r_inflight + (PW + 1)'(w_rd_acc) - (PW + 1)'(w_rdv);
        w_count_nx    = r_count + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
        w_rptr_nx     = r_rptr + PW'(w_pop);
        w_fill_nx     = w_start ? r_mode : r_fill;

        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nx = (r_numwords == 32'd0) ? S_DONE : S_RUN;
            S_RUN:   if (w_wr_cnt_nx == r_numwords) w_state_nx = S_DONE;
                     else if (w_abort)              w_state_nx = S_ABORT;
            S_ABORT: if (!w_hold && (w_inflight_nx == '0)) w_state_nx = S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
        w_flush = (w_state_nx == S_ABORT);

        // Next request is chosen from post-edge state, so the head may be the word pushed right now.
        w_head   = (w_push && (r_count == (PW + 1)'(w_pop))) ? mem.readdata : r_fifo[w_rptr_nx];
        w_can_wr = w_fill_nx ? (w_wr_cnt_nx < r_numwords) : (w_count_nx != '0);
        w_can_rd = !w_fill_nx && (w_rd_cnt_nx < r_numwords) &&
                   (({1'b0, w_inflight_nx} + {1'b0, w_count_nx}) < C_DEPTH);
    end

    always_comb begin
        w_rdata = 32'd0;
        case (csr.address)
            4'd0: w_rdata = {29'd0, r_aborted, r_done, w_busy};
            4'd1: w_rdata = r_dest;
            4'd2: w_rdata = r_src;
            4'd3: w_rdata = r_numwords;
            4'd4: w_rdata = {31'd0, r_mode};
            4'd5: w_rdata = r_pattern;
            4'd6: w_rdata = r_wr_cnt;
            4'd7: w_rdata = {31'd0, r_irq_en};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dest     <= '0;
            r_src      <= '0;
            r_numwords <= '0;
            r_pattern  <= '0;
            r_mode     <= 1'b0;
            r_fill     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_m_read   <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_rd_cnt   <= w_rd_cnt_nx;
            r_wr_cnt   <= w_wr_cnt_nx;
            r_inflight <= w_inflight_nx;
            r_fill     <= w_fill_nx;

            if (w_flush) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                r_count <= w_count_nx;
                r_rptr  <= w_rptr_nx;
                r_wptr  <= r_wptr + PW'(w_push);
            end
            if (w_push) r_fifo[r_wptr] <= mem.readdata;

            if (csr.write && !w_busy) begin
                case (csr.address)
                    4'd1: r_dest     <= csr.writedata;
                    4'd2: r_src      <= csr.writedata;
                    4'd3: r_numwords <= csr.writedata;
                    default: ;
                endcase
            end
            if (csr.write && csr.address == 4'd4) r_mode    <= csr.writedata[0];
            if (csr.write && csr.address == 4'd5) r_pattern <= csr.writedata;
            if (csr.write && csr.address == 4'd7) r_irq_en  <= csr.writedata[0];

            if (w_start || (csr.write && csr.address == 4'd7 && csr.writedata[1])) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end
            if (w_state_nx == S_DONE && r_state != S_DONE) begin
                r_done <= 1'b1;
                if (r_state == S_ABORT) r_aborted <= 1'b1;
            end

            if (!w_hold) begin
                r_m_read  <= 1'b0;
                r_m_write <= 1'b0;
                if (w_state_nx == S_RUN) begin
                    if (w_can_wr) begin
                        r_m_write <= 1'b1;
                        r_m_addr  <= AW'(r_dest) + AW'(w_wr_cnt_nx) * AW'(C_BYTES);
                        r_m_wdata <= w_fill_nx ? DW'(r_pattern) : w_head;
                    end else if (w_can_rd) begin
                        r_m_read  <= 1'b1;
                        r_m_addr  <= AW'(r_src) + AW'(w_rd_cnt_nx) * AW'(C_BYTES);
                    end
                end
            end
        end
    end

    assign csr.waitrequest   = 1'b0;
    assign csr.readdatavalid = 1'b0;
    assign csr.readdata      = w_rdata;
    assign mem.read          = r_m_read;
    assign mem.write         = r_m_write;
    assign mem.address       = r_m_addr;
    assign mem.writedata     = r_m_wdata;
    assign irq               = r_done && r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_wordcopy_dma.sv
// ============================================================================
// Module   : tb_wordcopy_dma
// Brief    : Directed bench for wordcopy_dma with a latency/stall SDRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wordcopy_dma;

    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    always #5 clk = ~clk;

    wordcopy_dma_if #(.DW(32), .AW(4))  csr_if ();
    wordcopy_dma_if #(.DW(32), .AW(32)) mem_if ();

    wordcopy_dma #(.DW(32), .AW(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .csr   (csr_if),
        .mem   (mem_if),
        .irq   (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fill;
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] num;
        logic [31:0] pat;
        bit          wt;
        int          lat;
        int          min_inf;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    // SDRAM model state
    logic        exp_fill = 1'b0;
    logic [31:0] exp_src = '0, exp_dest = '0, exp_pat = '0;
    bit          wait_en = 1'b0;
    int          lat = 1;
    int          cyc = 0, rd_n = 0, wr_n = 0, tb_inflight = 0, max_inflight = 0;
    resp_t       pend[$];
    bit          prev_hold = 1'b0, prev_wait = 1'b0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    function automatic logic [31:0] src_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (prev_hold && rst_n) begin
            chk("hold_read",  {31'd0, mem_if.read},  {31'd0, prev_rd});
            chk("hold_write", {31'd0, mem_if.write}, {31'd0, prev_wr});
            chk("hold_addr",  mem_if.address, prev_addr);
            chk("hold_wdata", mem_if.writedata, prev_wdata);
        end
        mem_if.readdatavalid = 1'b0;
        mem_if.readdata      = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_if.readdatavalid = 1'b1;
            mem_if.readdata      = pend[0].data;
            void'(pend.pop_front());
            tb_inflight--;
        end
        mem_if.waitrequest = (wait_en && !prev_wait) ? ($urandom_range(0, 1) == 1) : 1'b0;
        prev_wait = mem_if.waitrequest;
        if (mem_if.read && !mem_if.waitrequest) begin
            chk("read_in_copy_only", {31'd0, exp_fill}, 32'd0);
            chk("read_addr", mem_if.address, exp_src + 32'(rd_n) * 32'd4);
            pend.push_back('{cyc + lat, src_data(mem_if.address)});
            tb_inflight++;
            rd_n++;
            if (tb_inflight > max_inflight) max_inflight = tb_inflight;
            chk("inflight_le_depth", {31'd0, tb_inflight <= DEPTH}, 32'd1);
        end
        if (mem_if.write && !mem_if.waitrequest) begin
            chk("write_addr", mem_if.address, exp_dest + 32'(wr_n) * 32'd4);
            chk("write_data", mem_if.writedata,
                exp_fill ? exp_pat : src_data(exp_src + 32'(wr_n) * 32'd4));
            wr_n++;
        end
        prev_hold  = (mem_if.read || mem_if.write) && mem_if.waitrequest && rst_n;
        prev_rd    = mem_if.read;
        prev_wr    = mem_if.write;
        prev_addr  = mem_if.address;
        prev_wdata = mem_if.writedata;
    end

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_if.address   = a;
        csr_if.writedata = d;
        csr_if.write     = 1'b1;
        @(negedge clk);
        csr_if.write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_if.address = a;
        csr_if.read    = 1'b1;
        #1 d = csr_if.readdata;
        csr_if.read    = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            csr_rd(4'd0, s);
            if (s[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic setup_job(input vec_t v);
        exp_fill = v.fill; exp_src = v.src; exp_dest = v.dest; exp_pat = v.pat;
        wait_en = v.wt; lat = v.lat;
        rd_n = 0; wr_n = 0; max_inflight = 0;
        csr_wr(4'd1, v.dest);
        csr_wr(4'd2, v.src);
        csr_wr(4'd3, v.num);
        csr_wr(4'd4, {31'd0, v.fill});
        csr_wr(4'd5, v.pat);
    endtask

    vec_t        vecs[6];
    logic [31:0] rd;
    bit          ok;
    int          rd_snap, wr_snap;

    initial begin
        csr_if.address = '0; csr_if.read = 1'b0; csr_if.write = 1'b0; csr_if.writedata = '0;
        mem_if.waitrequest = 1'b0; mem_if.readdata = '0; mem_if.readdatavalid = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0200, 32'd4,  32'h0,          1'b0, 1,  1};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0000_0200, 32'd4,  32'h0,          1'b1, 10, 2};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0040, 32'd3,  32'hDEAD_BEEF,  1'b0, 1,  0};
        vecs[3] = '{1'b0, 32'h0000_1000, 32'h0000_3000, 32'd16, 32'h0,          1'b0, 10, 8};
        vecs[4] = '{1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd3,  32'h0,          1'b1, 3,  1};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0800, 32'd5,  32'h0000_A5A5,  1'b1, 1,  0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_read",   {31'd0, mem_if.read},  32'd0);
        chk("rst_write",  {31'd0, mem_if.write}, 32'd0);
        chk("rst_addr",   mem_if.address,   32'd0);
        chk("rst_wdata",  mem_if.writedata, 32'd0);
        chk("rst_irq",    {31'd0, irq},     32'd0);
        chk("rst_swait",  {31'd0, csr_if.waitrequest}, 32'd0);
        chk("rst_status", csr_if.readdata,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        csr_rd(4'd0, rd); chk("status_after_rst", rd, 32'd0);
        csr_rd(4'd6, rd); chk("progress_after_rst", rd, 32'd0);

        // Table-driven jobs
        for (int k = 0; k < 6; k++) begin
            setup_job(vecs[k]);
            csr_wr(4'd0, 32'd1);
            chk("first_request", {31'd0, vecs[k].fill ? mem_if.write : mem_if.read}, 32'd1);
            wait_idle(ok);
            chk("job_finished", {31'd0, ok}, 32'd1);
            csr_rd(4'd0, rd); chk("job_status", rd, 32'h2);
            csr_rd(4'd6, rd); chk("job_progress", rd, vecs[k].num);
            chk("job_writes", 32'(wr_n), vecs[k].num);
            chk("job_reads",  32'(rd_n), vecs[k].fill ? 32'd0 : vecs[k].num);
            chk("job_min_inflight", {31'd0, max_inflight >= vecs[k].min_inf}, 32'd1);
        end
        csr_rd(4'd5, rd); chk("pattern_readback", rd, 32'h0000_A5A5);
        csr_rd(4'd4, rd); chk("mode_readback", rd, 32'd1);

        // NUMWORDS=0: straight to done, no traffic
        setup_job('{1'b0, 32'h100, 32'h200, 32'd0, 32'h0, 1'b0, 1, 0});
        csr_wr(4'd0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            csr_rd(4'd0, rd);
            if (rd == 32'h2) ok = 1'b1;
        end
        chk("zero_len_done", {31'd0, ok}, 32'd1);
        repeat (5) @(negedge clk);
        chk("zero_len_reads",  32'(rd_n), 32'd0);
        chk("zero_len_writes", 32'(wr_n), 32'd0);

        // Abort after two words of a 16-word copy
        setup_job('{1'b0, 32'h100, 32'h200, 32'd16, 32'h0, 1'b0, 10, 0});
        csr_wr(4'd0, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wr_n >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_two_words_seen", {31'd0, ok}, 32'd1);
        csr_wr(4'd1, 32'h999);
        csr_wr(4'd0, 32'd2);
        rd_snap = rd_n;
        wr_snap = wr_n;
        wait_idle(ok);
        chk("abort_finished", {31'd0, ok}, 32'd1);
        chk("abort_drained", 32'(tb_inflight), 32'd0);
        csr_rd(4'd0, rd); chk("abort_status", rd, 32'h6);
        csr_rd(4'd6, rd);
        chk("abort_progress_lt16", {31'd0, rd < 32'd16}, 32'd1);
        chk("abort_progress_eq_writes", rd, 32'(wr_n));
        chk("abort_no_new_reads", 32'(rd_n), 32'(rd_snap));
        chk("abort_no_new_writes", 32'(wr_n), 32'(wr_snap));
        csr_rd(4'd1, rd); chk("dest_locked_while_busy", rd, 32'h200);

        // Interrupt enable and clear
        csr_wr(4'd7, 32'd1);
        chk("irq_set", {31'd0, irq}, 32'd1);
        csr_wr(4'd7, 32'd3);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        csr_rd(4'd0, rd); chk("status_cleared", rd, 32'd0);
        csr_rd(4'd7, rd); chk("irqctl_readback", rd, 32'd1);

        // Reset in the middle of a copy
        setup_job('{1'b0, 32'h400, 32'h600, 32'd16, 32'h0, 1'b1, 10, 0});
        csr_wr(4'd0, 32'd1);
        chk("first_request_rst_job", {31'd0, mem_if.read}, 32'd1);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        csr_if.address = 4'd0;
        #1;
        chk("midrst_read",   {31'd0, mem_if.read},  32'd0);
        chk("midrst_write",  {31'd0, mem_if.write}, 32'd0);
        chk("midrst_addr",   mem_if.address,   32'd0);
        chk("midrst_wdata",  mem_if.writedata, 32'd0);
        chk("midrst_irq",    {31'd0, irq},     32'd0);
        chk("midrst_status", csr_if.readdata,  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        rd_snap = rd_n;
        wr_snap = wr_n;
        repeat (30) @(negedge clk);
        chk("postrst_no_reads",  32'(rd_n), 32'(rd_snap));
        chk("postrst_no_writes", 32'(wr_n), 32'(wr_snap));
        csr_rd(4'd0, rd); chk("postrst_status", rd, 32'd0);
        csr_rd(4'd6, rd); chk("postrst_progress", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
